// File: rtl/data_send.sv
// LVDS transmit path: AXI4-Lite loaded sample buffer streamed out as 4-bit
// nibbles on LVDS_OUT with a divided, forwarded clock LVDS_CLK_OUT.
module data_send #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int BUFFER_WORDS       = 128,
  parameter int CLK_DIV            = 2
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [3:0]                      LVDS_OUT,
  output logic                            LVDS_CLK_OUT,
  output logic                            TX_ACTIVE
);

  localparam int AW = (BUFFER_WORDS > 1) ? $clog2(BUFFER_WORDS) : 1;
  localparam logic [15:0] PH_HI  = 16'(CLK_DIV - 1);
  localparam logic [15:0] PH_END = 16'(2 * CLK_DIV - 1);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t      state;
  logic [31:0] mem [BUFFER_WORDS];
  logic [7:0]  len, tx_len, word;
  logic [7:0]  word_nx;
  logic [2:0]  nib;
  logic [15:0] ph;
  logic [27:0] shreg;
  logic        done;

  logic        busy, wr_en, wr_buf, rd_buf, abort_req, start_req, last;
  logic [7:0]  wr_reg, rd_reg, len_sat;
  logic [31:0] rd_val;
  logic        unused_ok;

  assign busy      = (state == SEND);
  assign wr_reg    = S_AXI_AWADDR[9:2];
  assign rd_reg    = S_AXI_ARADDR[9:2];
  assign wr_en     = S_AXI_AWREADY & S_AXI_AWVALID & S_AXI_WVALID;
  assign wr_buf    = wr_reg[7] && ({1'b0, wr_reg[6:0]} < 8'(BUFFER_WORDS));
  assign rd_buf    = rd_reg[7] && ({1'b0, rd_reg[6:0]} < 8'(BUFFER_WORDS));
  assign abort_req = wr_en && (wr_reg == 8'd0) && S_AXI_WDATA[1] && busy;
  assign start_req = wr_en && (wr_reg == 8'd0) && S_AXI_WDATA[0] && !busy;
  assign len_sat   = (S_AXI_WDATA > 32'(BUFFER_WORDS)) ? 8'(BUFFER_WORDS) : S_AXI_WDATA[7:0];
  assign word_nx   = word + 8'd1;
  assign last      = (nib == 3'd7) && (word_nx == tx_len);
  assign S_AXI_RRESP = 2'b00;
  assign unused_ok = ^{S_AXI_WSTRB, S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:10], S_AXI_AWADDR[1:0],
                       S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:10], S_AXI_ARADDR[1:0]};

  always_comb begin
    rd_val = '0;
    if (rd_reg == 8'd1)      rd_val = {30'd0, done, busy};
    else if (rd_reg == 8'd2) rd_val = {24'd0, len};
    else if (rd_buf)         rd_val = mem[rd_reg[AW-1:0]];
  end

  // Buffer is frozen while sending so the serialiser can read it directly.
  always_ff @(posedge S_AXI_ACLK) begin
    if (wr_en && wr_buf && !busy) mem[wr_reg[AW-1:0]] <= S_AXI_WDATA;
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= 2'b00;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      LVDS_OUT      <= '0;
      LVDS_CLK_OUT  <= 1'b0;
      TX_ACTIVE     <= 1'b0;
      state         <= IDLE;
      len           <= '0;
      tx_len        <= '0;
      word          <= '0;
      nib           <= '0;
      ph            <= '0;
      shreg         <= '0;
      done          <= 1'b0;
    end else begin
      S_AXI_AWREADY <= S_AXI_AWVALID & S_AXI_WVALID & ~S_AXI_BVALID & ~S_AXI_AWREADY;
      S_AXI_WREADY  <= S_AXI_AWVALID & S_AXI_WVALID & ~S_AXI_BVALID & ~S_AXI_AWREADY;
      if (wr_en) begin
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= (wr_buf && busy) ? 2'b10 : 2'b00;
      end else if (S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end

      S_AXI_ARREADY <= S_AXI_ARVALID & ~S_AXI_RVALID & ~S_AXI_ARREADY;
      if (S_AXI_ARREADY && S_AXI_ARVALID) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rd_val;
      end else if (S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end

      if (wr_en && (wr_reg == 8'd2)) len <= len_sat;
      if (wr_en && (wr_reg == 8'd1) && S_AXI_WDATA[1]) done <= 1'b0;

      // Completion's DONE set comes after the SR clear so that set wins.
      if (start_req) begin
        if (len != 8'd0) begin
          state        <= SEND;
          tx_len       <= len;
          word         <= '0;
          nib          <= '0;
          ph           <= '0;
          LVDS_OUT     <= mem[AW'(0)][3:0];
          shreg        <= mem[AW'(0)][31:4];
          LVDS_CLK_OUT <= 1'b0;
          TX_ACTIVE    <= 1'b1;
          done         <= 1'b0;
        end else begin
          done <= 1'b1;
        end
      end else if (abort_req) begin
        state        <= IDLE;
        LVDS_OUT     <= '0;
        LVDS_CLK_OUT <= 1'b0;
        TX_ACTIVE    <= 1'b0;
      end else if (busy) begin
        if (ph == PH_END) begin
          ph           <= '0;
          LVDS_CLK_OUT <= 1'b0;
          if (last) begin
            state     <= IDLE;
            LVDS_OUT  <= '0;
            TX_ACTIVE <= 1'b0;
            done      <= 1'b1;
          end else if (nib == 3'd7) begin
            nib      <= '0;
            word     <= word_nx;
            LVDS_OUT <= mem[word_nx[AW-1:0]][3:0];
            shreg    <= mem[word_nx[AW-1:0]][31:4];
          end else begin
            nib      <= nib + 3'd1;
            LVDS_OUT <= shreg[3:0];
            shreg    <= {4'd0, shreg[27:4]};
          end
        end else begin
          ph <= ph + 16'd1;
          if (ph == PH_HI) LVDS_CLK_OUT <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/data_send.md
Name: data_send

Overview:
- Transmit-side counterpart of the LVDS capture path.
- Software loads a sample buffer and a length over AXI4-Lite, then writes CR.START. The block streams the buffer out as 4-bit nibbles on LVDS_OUT with a forwarded clock LVDS_CLK_OUT.
- The whole block runs on the AXI clock; LVDS_CLK_OUT is generated internally by division, and receivers sample LVDS_OUT on its rising edge.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, AXI data width; fixed at 32.
- C_S_AXI_ADDR_WIDTH, 32, AXI address width; only bits [9:2] are decoded.
- BUFFER_WORDS, 128, depth of the 32-bit transmit buffer; maximum 128.
- CLK_DIV, 2, half-period of LVDS_CLK_OUT in S_AXI_ACLK cycles; must be >= 1.

Ports:
- S_AXI_ACLK  in  1  the single clock.
- S_AXI_ARESET  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR  in  32  write address.
- S_AXI_AWVALID  in  1  write address valid.
- S_AXI_AWREADY  out  1  write address ready.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte strobes; ignored, all writes are full-word.
- S_AXI_WVALID  in  1  write data valid.
- S_AXI_WREADY  out  1  write data ready.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID  out  1  write response valid.
- S_AXI_BREADY  in  1  write response ready.
- S_AXI_ARADDR  in  32  read address.
- S_AXI_ARVALID  in  1  read address valid.
- S_AXI_ARREADY  out  1  read address ready.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response; always OKAY.
- S_AXI_RVALID  out  1  read data valid.
- S_AXI_RREADY  in  1  read data ready.
- LVDS_OUT  out  4  transmitted nibble.
- LVDS_CLK_OUT  out  1  forwarded data clock.
- TX_ACTIVE  out  1  high while in SEND; drives line-driver enables.

Behaviour:
- Register map (byte offsets, decoded on addr[9:2]):
  - 0x000 CR, write-only, self-clearing: bit0 START, bit1 ABORT.
  - 0x004 SR: bit0 BUSY (read-only, reads 1 in SEND); bit1 DONE (sticky, write 1 to clear).
  - 0x008 LEN, R/W, 8 bits, transmit length in words. Written values above BUFFER_WORDS saturate to BUFFER_WORDS.
  - 0x200–0x3FF buffer word i at 0x200+4*i, R/W.
  - Other addresses: reads return 0, writes are ignored; both respond OKAY.
- Reset values:
  - All AXI valid/ready outputs 0; BRESP/RRESP 0; RDATA 0.
  - LVDS_OUT 0, LVDS_CLK_OUT 0, TX_ACTIVE 0.
  - LEN 0, DONE 0, state IDLE. Buffer contents are not reset.
  - Reset mid-SEND returns to these values immediately.
- Write handshake:
  - AWREADY and WREADY pulse together for one cycle when AWVALID & WVALID & ~BVALID.
  - BVALID rises the next cycle and holds until BREADY.
  - BRESP = SLVERR (2'b10) for a buffer write while BUSY; the write is dropped. All other writes return OKAY.
- Read handshake:
  - ARREADY pulses for one cycle when ARVALID & ~RVALID.
  - RDATA/RVALID are valid the next cycle and held until RREADY.
  - Buffer reads are allowed in any state.
- State machine:
  - IDLE → SEND on a CR.START write when LEN != 0. This clears DONE and zeroes the word and nibble counters.
  - START with LEN == 0: no transition; DONE is set.
  - START while in SEND is ignored.
  - SEND → IDLE after the last nibble period completes; DONE is set on that same cycle.
  - ABORT write in SEND → IDLE on the next cycle; DONE is not set.
- Serialiser:
  - One nibble period is 2*CLK_DIV cycles: LVDS_CLK_OUT is low for the first CLK_DIV cycles, then high for CLK_DIV cycles.
  - LVDS_OUT updates at the start of each period, i.e. on the falling edge of LVDS_CLK_OUT.
  - Order: word 0 first, ascending; within a word bits[3:0] first, then [7:4] … [31:28].
  - Total of 8*LEN periods.
  - First nibble appears on LVDS_OUT no later than 2 cycles after the BVALID cycle of the START write.
- IDLE outputs: LVDS_OUT = 0, LVDS_CLK_OUT = 0, TX_ACTIVE = 0. TX_ACTIVE is registered and high for exactly the SEND duration.
- Simultaneous events: an SR DONE-clear write on the same cycle that DONE is set → set wins.

Test Plan:
- Reset, then read 0x000/0x004/0x008 → all 0; LVDS_OUT = 0, TX_ACTIVE = 0.
- Write buf[0] = 0x76543210, LEN = 1, START, CLK_DIV = 2 → LVDS_OUT sequence 0,1,…,7 with each nibble held 4 cycles. LVDS_CLK_OUT rises 2 cycles into each period. TX_ACTIVE high for 32 cycles, then SR = 0x2.
- LEN = 3 with buf = {0xAAAAAAAA, 0x55555555, 0xF0F0F0F0} → 24 nibbles in order A×8, 5×8, (0,F)×4. During the transfer, a buffer write gets BRESP = 2'b10 and readback shows the old value.
- START, then ABORT after 5 nibbles → LVDS_OUT = 0 and TX_ACTIVE = 0 within 1 cycle; SR = 0x0.
- Write LEN = 200 → LEN reads 128. LEN = 0 then START → no TX_ACTIVE, SR = 0x2. Write SR = 0x2 → SR = 0x0.
- Assert S_AXI_ARESET mid-SEND → all outputs 0 asynchronously. After release, the buffer still reads the previously written data.
